cursor_controller: RTL and testbench
====================================

Name: cursor_controller

Overview:
- Writer side of the oscilloscope cursor interface: converts the DE1-SoC pushbuttons and slide switches into the four 11-bit cursor positions consumed by the VGA display block.
- Replaces the hard-coded cursor registers in the top level.
- Keys are synchronised and debounced; each accepted press issues one step; a held key auto-repeats.
- Results are clamped to the visible area.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-press cycles before first step (10 ms at 50 MHz)
- REPEAT_DELAY, 25000000, cycles after first step before auto-repeat starts
- REPEAT_PERIOD, 2500000, cycles between auto-repeat steps
- STEP, 1, pixels moved per step (1..63)
- X_MAX, 639, maximum X cursor value
- Y_MAX, 479, maximum Y cursor value
- X1_INIT / X2_INIT / Y1_INIT / Y2_INIT, 32 / 90 / 25 / 100, reset positions

Ports:
- clock  in  1  50 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- key_inc_n  in  1  raw pushbutton, active-low, increment
- key_dec_n  in  1  raw pushbutton, active-low, decrement
- switch0  in  1  X-axis move enable
- switch1  in  1  Y-axis move enable
- sel_cursor  in  1  0 = cursor 1, 1 = cursor 2
- cursorX1, cursorX2, cursorY1, cursorY2  out  11 each  cursor positions
- move_pulse  out  1  one-cycle strobe on each step event

Behaviour:
- Clock and reset: one clock domain (clock). reset_n is asynchronous, active-low.
- Reset values: cursors = *_INIT; move_pulse = 0; FSM = IDLE; counter = 0; key synchronisers = 1 (released); switch/select synchronisers = 0.
- Synchronisers: all five inputs pass through 2-FF synchronisers. All later references mean the synchronised values.
- Command decode:
  - cmd = INC when only inc is pressed.
  - cmd = DEC when only dec is pressed.
  - cmd = NONE when neither key or both keys are pressed.
- FSM states: IDLE, DEBOUNCE, HOLD, REPEAT. One counter is shared and cleared on every state entry.
  - IDLE: cmd != NONE -> latch cmd, go to DEBOUNCE.
  - DEBOUNCE: cmd != latched -> IDLE, no step. Counter == DEBOUNCE_CYCLES-1 -> step, go to HOLD.
  - HOLD: cmd != latched -> IDLE. Counter == REPEAT_DELAY-1 -> step, go to REPEAT.
  - REPEAT: cmd != latched -> IDLE. Counter == REPEAT_PERIOD-1 -> step, counter = 0, stay in REPEAT.
  - The cmd-change check takes priority over the terminal count in the same cycle.
- Step event:
  - Registered on the terminal-count edge; cursor outputs and move_pulse update on that same edge (move_pulse high for exactly one cycle).
  - Targets: X of the selected cursor if switch0 = 1; Y of the selected cursor if switch1 = 1; both if both are 1.
  - With neither switch set, move_pulse still fires and no cursor changes.
  - switch0, switch1 and sel_cursor are sampled at the step cycle, not latched at press. A change mid-hold affects only later steps.
- Arithmetic:
  - Computed 12 bits wide; no wrap-around.
  - INC: new = min(cur + STEP, MAX), where MAX = X_MAX or Y_MAX.
  - DEC: new = cur - STEP if cur >= STEP, else 0.
  - At a limit the value holds, and move_pulse is still asserted.
- Non-selected cursors and non-enabled axes never change.
- Release after any number of steps returns to IDLE. A re-press needs a full fresh debounce.
- reset_n asserted in any state: immediate return to reset values, with no pulse and no partial step.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
1. Reset: assert reset_n=0 mid-run -> outputs 32/90/25/100 immediately, move_pulse=0. Release -> FSM IDLE, no step without keys.
2. Glitch rejection: switch0=1, sel_cursor=0, key_inc_n low for 3 synchronised cycles then high -> cursorX1 stays 32, no move_pulse.
3. Held key with auto-repeat: key_inc_n held low -> cursorX1 = 33 exactly 4 cycles after synchronised press; 34 after 8 more cycles; then 35, 36, ... every 3 cycles, one move_pulse each. Release -> no further change.
4. Clamping with STEP=10: switch1=1, key_dec_n held -> cursorY1 25 -> 15 -> 5 -> 0 -> 0, with move_pulse on each step. With X_MAX=35 and STEP=1, inc held -> cursorX1 stops at 35.
5. Conflicts and multi-axis:
   - Both keys low -> no step ever.
   - switch0=switch1=1, sel_cursor=1, inc press -> cursorX2 = 91 and cursorY2 = 101 on the same edge; cursor 1 unchanged.
6. Reset during REPEAT: reset mid-repeat -> reset values, no pulse. After reset release with the key still held, the first step comes only after a full 4-cycle debounce.

Source files
------------

// File: rtl/cursor_controller.sv
// ---------------------------------------------------------------------------
// cursor_controller
//   Turns the two DE1-SoC pushbuttons plus the axis/select slide switches into
//   the four 11-bit oscilloscope cursor positions used by the VGA block.
//   Keys are synchronised and debounced. An accepted press issues one step,
//   and a held key auto-repeats. Every result is clamped to the visible area.
//
// Ports
//   clock       in   system clock (50 MHz)
//   reset_n     in   asynchronous active-low reset
//   key_inc_n   in   raw increment pushbutton, active-low
//   key_dec_n   in   raw decrement pushbutton, active-low
//   switch0     in   X-axis move enable
//   switch1     in   Y-axis move enable
//   sel_cursor  in   0 = cursor 1, 1 = cursor 2
//   cursorX1/X2/Y1/Y2  out  cursor positions, 11 bits each
//   move_pulse  out  one-cycle strobe on every step event
// ---------------------------------------------------------------------------
module cursor_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 2500000,
    parameter int unsigned STEP            = 1,
    parameter int unsigned X_MAX           = 639,
    parameter int unsigned Y_MAX           = 479,
    parameter int unsigned X1_INIT         = 32,
    parameter int unsigned X2_INIT         = 90,
    parameter int unsigned Y1_INIT         = 25,
    parameter int unsigned Y2_INIT         = 100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_inc_n,
    input  logic        key_dec_n,
    input  logic        switch0,
    input  logic        switch1,
    input  logic        sel_cursor,
    output logic [10:0] cursorX1,
    output logic [10:0] cursorX2,
    output logic [10:0] cursorY1,
    output logic [10:0] cursorY2,
    output logic        move_pulse
);

    // The counter is shared by all three timed states, so size it for the longest.
    localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [11:0] XLIM12 = 12'(X_MAX);
    localparam logic [11:0] YLIM12 = 12'(Y_MAX);

    // Synchroniser bit layout: {sel, sw1, sw0, dec_n, inc_n}.
    // The keys reset to released (1) and the switches reset to 0.
    localparam logic [4:0] SYNC_RST = 5'b00011;

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HOLD, S_REPEAT} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_INC, CMD_DEC} cmd_t;

    logic [4:0]       sync1_q, sync2_q;
    logic             inc_s, dec_s, sw0_s, sw1_s, sel_s;
    cmd_t             cmd;

    state_t           state_q;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [10:0]      x1_q, x2_q, y1_q, y2_q;
    logic             pulse_q;

    logic             term;
    logic             step;
    logic             up;
    logic [10:0]      x_cur, y_cur, x_nxt, y_nxt;

    // ---------------- input synchronisers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {sel_cursor, switch1, switch0, key_dec_n, key_inc_n};
            sync2_q <= sync1_q;
        end
    end

    assign inc_s = ~sync2_q[0];
    assign dec_s = ~sync2_q[1];
    assign sw0_s = sync2_q[2];
    assign sw1_s = sync2_q[3];
    assign sel_s = sync2_q[4];

    // Pressing both keys at once counts as no command.
    always_comb begin
        cmd = CMD_NONE;
        if (inc_s && !dec_s)      cmd = CMD_INC;
        else if (dec_s && !inc_s) cmd = CMD_DEC;
    end

    // ---------------- step detection ----------------
    always_comb begin
        term = 1'b0;
        case (state_q)
            S_DEBOUNCE: term = (cnt_q == DEB_LAST);
            S_HOLD:     term = (cnt_q == DLY_LAST);
            S_REPEAT:   term = (cnt_q == PER_LAST);
            default:    term = 1'b0;
        endcase
    end

    // A command change beats the terminal count, so a step needs the command to be unchanged.
    assign step = (state_q != S_IDLE) && (cmd == cmd_q) && term;
    assign up   = (cmd_q == CMD_INC);

    // The saturating step is computed 12 bits wide, so the sum cannot wrap before the clamp.
    function automatic logic [10:0] move(input logic [10:0] cur, input logic inc,
                                         input logic [11:0] lim);
        logic [11:0] sum;
        sum = {1'b0, cur} + STEP12;
        if (inc)
            move = (sum > lim) ? lim[10:0] : sum[10:0];
        else
            move = ({1'b0, cur} >= STEP12) ? (cur - STEP12[10:0]) : 11'd0;
    endfunction

    always_comb begin
        x_cur = sel_s ? x2_q : x1_q;
        y_cur = sel_s ? y2_q : y1_q;
        x_nxt = move(x_cur, up, XLIM12);
        y_nxt = move(y_cur, up, YLIM12);
    end

    // ---------------- control FSM and output registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_NONE;
            cnt_q   <= '0;
            x1_q    <= 11'(X1_INIT);
            x2_q    <= 11'(X2_INIT);
            y1_q    <= 11'(Y1_INIT);
            y2_q    <= 11'(Y2_INIT);
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= step;

            // The axis and cursor select are taken at the step cycle itself.
            if (step) begin
                if (sw0_s) begin
                    if (sel_s) x2_q <= x_nxt;
                    else       x1_q <= x_nxt;
                end
                if (sw1_s) begin
                    if (sel_s) y2_q <= y_nxt;
                    else       y1_q <= y_nxt;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd != CMD_NONE) begin
                        cmd_q   <= cmd;
                        state_q <= S_DEBOUNCE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (cmd != cmd_q) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (term) begin
                        cnt_q <= '0;
                        if (state_q == S_DEBOUNCE) state_q <= S_HOLD;
                        else                       state_q <= S_REPEAT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign cursorX1   = x1_q;
    assign cursorX2   = x2_q;
    assign cursorY1   = y1_q;
    assign cursorY2   = y2_q;
    assign move_pulse = pulse_q;

endmodule

// File: tb/tb_cursor_controller.sv
// ---------------------------------------------------------------------------
// tb_cursor_controller
//   Three instances share one set of inputs:
//     0: STEP=1,  X_MAX=639   (normal stepping and auto-repeat timing)
//     1: STEP=10, X_MAX=639   (clamping at 0 while decrementing)
//     2: STEP=1,  X_MAX=35    (clamping at the upper limit while incrementing)
//   The reference model works from the press timeline. k counts the edges
//   since the command was latched. Steps fall at k = D, then D+R, then every
//   P after that.
// ---------------------------------------------------------------------------
module tb_cursor_controller;

    localparam int D = 4;
    localparam int R = 8;
    localparam int P = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic key_inc_n = 1'b1, key_dec_n = 1'b1;
    logic switch0 = 1'b0, switch1 = 1'b0, sel_cursor = 1'b0;

    // cur_o[inst][0..3] = X1, X2, Y1, Y2
    logic [2:0][3:0][10:0] cur_o;
    logic [2:0]            mp_o;

    always #5 clock = ~clock;

    cursor_controller #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P),
                        .STEP(1), .X_MAX(639), .Y_MAX(479)) u_a (
        .clock(clock), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .switch0(switch0), .switch1(switch1), .sel_cursor(sel_cursor),
        .cursorX1(cur_o[0][0]), .cursorX2(cur_o[0][1]), .cursorY1(cur_o[0][2]),
        .cursorY2(cur_o[0][3]), .move_pulse(mp_o[0]));

    cursor_controller #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P),
                        .STEP(10), .X_MAX(639), .Y_MAX(479)) u_b (
        .clock(clock), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .switch0(switch0), .switch1(switch1), .sel_cursor(sel_cursor),
        .cursorX1(cur_o[1][0]), .cursorX2(cur_o[1][1]), .cursorY1(cur_o[1][2]),
        .cursorY2(cur_o[1][3]), .move_pulse(mp_o[1]));

    cursor_controller #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P),
                        .STEP(1), .X_MAX(35), .Y_MAX(479)) u_c (
        .clock(clock), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .switch0(switch0), .switch1(switch1), .sel_cursor(sel_cursor),
        .cursorX1(cur_o[2][0]), .cursorX2(cur_o[2][1]), .cursorY1(cur_o[2][2]),
        .cursorY2(cur_o[2][3]), .move_pulse(mp_o[2]));

    int nvec = 0;
    int nerr = 0;

    // ---------------- reference model ----------------
    int m_step [3] = '{1, 10, 1};
    int m_xmax [3] = '{639, 639, 35};
    int m_cur  [3][4];
    bit m_mp   [3];
    logic [4:0] ms1, ms2;   // {sel, sw1, sw0, dec_n, inc_n}
    bit m_act;
    int m_lat;
    int m_k;
    int m_c;
    bit m_stp;
    int m_sel;

    function automatic int apply(input int cur, input int lat, input int st, input int mx);
        if (lat == 1) return (cur + st > mx) ? mx : cur + st;
        return (cur >= st) ? cur - st : 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cur[i] = '{32, 90, 25, 100};
                m_mp[i]  = 1'b0;
            end
            ms1 = 5'b00011;
            ms2 = 5'b00011;
            m_act = 1'b0;
            m_k = 0;
            m_lat = 0;
        end else begin
            m_c = (!ms2[0] && ms2[1]) ? 1 : ((ms2[0] && !ms2[1]) ? 2 : 0);
            m_stp = 1'b0;
            if (!m_act) begin
                if (m_c != 0) begin
                    m_act = 1'b1;
                    m_lat = m_c;
                    m_k = 0;
                end
            end else if (m_c != m_lat) begin
                m_act = 1'b0;
            end else begin
                m_k++;
                if (m_k == D || (m_k >= D + R && (m_k - D - R) % P == 0)) m_stp = 1'b1;
            end
            m_sel = ms2[4] ? 1 : 0;
            for (int i = 0; i < 3; i++) begin
                m_mp[i] = m_stp;
                if (m_stp && ms2[2]) m_cur[i][m_sel] = apply(m_cur[i][m_sel], m_lat, m_step[i], m_xmax[i]);
                if (m_stp && ms2[3]) m_cur[i][2 + m_sel] = apply(m_cur[i][2 + m_sel], m_lat, m_step[i], 479);
            end
            ms2 = ms1;
            ms1 = {sel_cursor, switch1, switch0, key_dec_n, key_inc_n};
        end
    end

    function automatic logic [2:0][44:0] dut_vec();
        logic [2:0][44:0] r;
        for (int i = 0; i < 3; i++) r[i] = {cur_o[i], mp_o[i]};
        return r;
    endfunction

    function automatic logic [2:0][44:0] exp_vec();
        logic [2:0][44:0] r;
        for (int i = 0; i < 3; i++)
            r[i] = {11'(m_cur[i][3]), 11'(m_cur[i][2]), 11'(m_cur[i][1]), 11'(m_cur[i][0]), m_mp[i]};
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (cur_o[i] !== {11'd100, 11'd25, 11'd90, 11'd32} || mp_o[i] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_init inst%0d: got %h/%b want 100/25/90/32 pulse 0", i, cur_o[i], mp_o[i]);
            end
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        switch0 = 1'b1;
        key_inc_n = 1'b0;
        repeat (20) begin
            @(negedge clock);
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL reset_run: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        // Assert reset between edges: the outputs must return at once, with no pulse.
        #2 reset_n = 1'b0;
        key_inc_n = 1'b1;
        switch0 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (cur_o[i] !== {11'd100, 11'd25, 11'd90, 11'd32} || mp_o[i] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_midrun inst%0d: got %h/%b want 100/25/90/32 pulse 0", i, cur_o[i], mp_o[i]);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            nvec++;
            if (dut_vec() !== exp_vec() || mp_o !== 3'b000) begin
                nerr++;
                $display("FAIL reset_idle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        switch0 = 1'b1;
        sel_cursor = 1'b0;
        key_inc_n = 1'b0;
        repeat (3) @(negedge clock);
        key_inc_n = 1'b1;
        repeat (12) begin
            @(negedge clock);
            nvec++;
            if (dut_vec() !== exp_vec() || cur_o[0][0] !== 11'd32 || mp_o !== 3'b000) begin
                nerr++;
                $display("FAIL glitch: x1=%0d pulse=%b want 32/000 dut=%h model=%h",
                         cur_o[0][0], mp_o, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        int ce, n, ex;
        bit ep;
        switch0 = 1'b1;
        switch1 = 1'b0;
        sel_cursor = 1'b0;
        key_inc_n = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clock);
            if (c == 23) key_inc_n = 1'b1;   // the key is still seen through edge 25
            ce = (c > 25) ? 25 : c;
            n  = (ce >= 7 ? 1 : 0) + (ce >= 15 ? 1 + (ce - 15) / 3 : 0);
            ex = 32 + n;
            ep = (c <= 25) && (c == 7 || (c >= 15 && (c - 15) % 3 == 0));
            nvec++;
            if (cur_o[0][0] !== 11'(ex) || mp_o[0] !== ep || dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL hold c=%0d: x1=%0d pulse=%b want %0d/%b dut=%h model=%h",
                         c, cur_o[0][0], mp_o[0], ex, ep, dut_vec(), exp_vec());
            end
        end
        nvec++;
        if (cur_o[2][0] !== 11'd35) begin
            nerr++;
            $display("FAIL clamp_xmax: x1=%0d want 35", cur_o[2][0]);
        end
    endtask

    task automatic test_clamp();
        int ce, n, ey;
        switch0 = 1'b0;
        switch1 = 1'b1;
        sel_cursor = 1'b0;
        key_dec_n = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clock);
            if (c == 22) key_dec_n = 1'b1;
            ce = (c > 24) ? 24 : c;
            n  = (ce >= 7 ? 1 : 0) + (ce >= 15 ? 1 + (ce - 15) / 3 : 0);
            ey = (25 - 10 * n > 0) ? 25 - 10 * n : 0;
            nvec++;
            if (cur_o[1][2] !== 11'(ey) || dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL clamp_zero c=%0d: y1=%0d want %0d dut=%h model=%h",
                         c, cur_o[1][2], ey, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_conflict();
        int x1_before, y1_before;
        switch0 = 1'b1;
        switch1 = 1'b0;
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        repeat (30) begin
            @(negedge clock);
            nvec++;
            if (mp_o !== 3'b000 || dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL both_keys: pulse=%b want 000 dut=%h model=%h", mp_o, dut_vec(), exp_vec());
            end
        end
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        repeat (5) @(negedge clock);
        x1_before = m_cur[0][0];
        y1_before = m_cur[0][2];
        switch0 = 1'b1;
        switch1 = 1'b1;
        sel_cursor = 1'b1;
        key_inc_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 8) key_inc_n = 1'b1;
            if (c == 7) begin
                nvec++;
                if (cur_o[0][1] !== 11'd91 || cur_o[0][3] !== 11'd101 || mp_o[0] !== 1'b1 ||
                    cur_o[0][0] !== 11'(x1_before) || cur_o[0][2] !== 11'(y1_before)) begin
                    nerr++;
                    $display("FAIL multi_axis: x2=%0d y2=%0d pulse=%b x1=%0d y1=%0d want 91/101/1/%0d/%0d",
                             cur_o[0][1], cur_o[0][3], mp_o[0], cur_o[0][0], cur_o[0][2], x1_before, y1_before);
                end
            end
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL multi_run c=%0d: dut=%h model=%h", c, dut_vec(), exp_vec());
            end
        end
        switch1 = 1'b0;
        sel_cursor = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_repeat();
        bit ep;
        switch0 = 1'b1;
        switch1 = 1'b0;
        sel_cursor = 1'b0;
        key_inc_n = 1'b0;
        repeat (19) begin
            @(negedge clock);
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL rr_pre: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        #2 reset_n = 1'b0;
        #1;
        nvec++;
        if (cur_o[0] !== {11'd100, 11'd25, 11'd90, 11'd32} || mp_o !== 3'b000) begin
            nerr++;
            $display("FAIL rr_reset: got %h/%b want 100/25/90/32 pulse 000", cur_o[0], mp_o);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;                       // the key is still held
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            ep = (c == 7);
            nvec++;
            if (mp_o[0] !== ep || cur_o[0][0] !== ((c >= 7) ? 11'd33 : 11'd32) || dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL rr_debounce c=%0d: x1=%0d pulse=%b want %0d/%b", c, cur_o[0][0], mp_o[0],
                         (c >= 7) ? 33 : 32, ep);
            end
        end
        key_inc_n = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_random();
        int hold;
        int pat;
        hold = 0;
        repeat (600) begin
            @(negedge clock);
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL random @%0t: dut=%h model=%h", $time, dut_vec(), exp_vec());
            end
            if (hold == 0) begin
                pat = $urandom_range(0, 3);
                key_inc_n = pat[0];
                key_dec_n = pat[1];
                hold = $urandom_range(1, 30);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 15) == 0) switch0 = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) switch1 = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) sel_cursor = $urandom_range(0, 1) == 1;
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_hold();
        test_clamp();
        test_conflict();
        test_reset_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
